// File: rtl/char_ram_pkg.sv
// Shared constants, register map, FSM state types and the port-A request
// record for the character RAM controller.
package char_ram_pkg;

    localparam int COLS   = 30;
    localparam int ROWS   = 20;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int WB_W   = 32;

    // Address-width versions of the geometry, used by comparators and counters.
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_A       = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A        = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_LAST_A = ADDR_W'(CELLS - COLS - 1);

    // Register offsets within the register window (wb_adr_i[1:0]).
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_FILL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    // Bit positions inside CTRL and STATUS.
    localparam int CTRL_CLR_BIT  = 0;
    localparam int CTRL_SCR_BIT  = 1;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_CLR,
        ENG_SCR_RD,
        ENG_SCR_WR,
        ENG_FILL_ROW,
        ENG_DONE
    } eng_state_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RD_WAIT,
        BUS_ACK
    } bus_state_e;

    // One port-A operation. din_from_rd routes the RAM read data straight
    // back into the write port (scroll copy).
    typedef struct packed {
        logic              ce;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              din_from_rd;
    } port_req_t;

endpackage

// File: rtl/char_ram_ctrl_if.sv
// Wishbone classic slave bus as seen by the character RAM controller.
interface char_ram_ctrl_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [10:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/char_ram_engine.sv
// Screen clear / scroll-up engine. req_o is the port-A operation for the
// NEXT cycle; the top registers it, so an op requested here appears on the
// RAM pins one cycle later, in the same cycle the engine state advances to.
module char_ram_engine
    import char_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_clr_i,
    input  logic              start_scr_i,
    input  logic [DATA_W-1:0] fill_i,
    output port_req_t         req_o,
    output logic              busy_o,
    output logic              done_irq_o
);

    eng_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, counter and next-cycle port request.
    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        req_o   = '0;

        case (state_q)
            ENG_IDLE, ENG_DONE: begin
                // DONE is a single cycle; a new start is accepted there too
                // because busy_o is already low.
                state_d = ENG_IDLE;
                busy_d  = 1'b0;
                if (start_clr_i) begin
                    state_d     = ENG_CLR;
                    cnt_d       = '0;
                    fill_d      = fill_i;
                    busy_d      = 1'b1;
                    req_o.ce    = 1'b1;
                    req_o.we    = 1'b1;
                    req_o.addr  = '0;
                    req_o.din   = fill_i;
                end else if (start_scr_i) begin
                    state_d     = ENG_SCR_RD;
                    cnt_d       = '0;
                    fill_d      = fill_i;
                    busy_d      = 1'b1;
                    req_o.ce    = 1'b1;
                    req_o.addr  = COLS_A;
                end
            end

            ENG_CLR, ENG_FILL_ROW: begin
                // Both write the sampled fill word up to the last cell.
                if (cnt_q == LAST_A) begin
                    state_d = ENG_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    req_o.ce   = 1'b1;
                    req_o.we   = 1'b1;
                    req_o.addr = cnt_d;
                    req_o.din  = fill_q;
                end
            end

            ENG_SCR_RD: begin
                // Word read from cnt+COLS arrives while the write is on the pins.
                state_d           = ENG_SCR_WR;
                req_o.ce          = 1'b1;
                req_o.we          = 1'b1;
                req_o.addr        = cnt_q;
                req_o.din_from_rd = 1'b1;
            end

            ENG_SCR_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SCROLL_LAST_A) begin
                    state_d    = ENG_FILL_ROW;
                    req_o.ce   = 1'b1;
                    req_o.we   = 1'b1;
                    req_o.addr = cnt_d;
                    req_o.din  = fill_q;
                end else begin
                    state_d    = ENG_SCR_RD;
                    req_o.ce   = 1'b1;
                    req_o.addr = cnt_d + COLS_A;
                end
            end

            default: begin
                state_d = ENG_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Engine state register; reset aborts any run immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (!rst_n) begin
            state_q <= ENG_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_irq_o = done_q;

endmodule

// File: rtl/char_ram_ctrl.sv
// Port-A controller for the 30x20 character RAM: Wishbone classic slave with
// a RAM window and control registers, plus the clear/scroll engine, which
// owns port A for the whole of a run.
module char_ram_ctrl
    import char_ram_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    char_ram_ctrl_if.slave      bus,
    output logic                ram_ce_a,
    output logic                ram_we_a,
    output logic [ADDR_W-1:0]   ram_addr_a,
    output logic [DATA_W-1:0]   ram_din_a,
    input  logic [DATA_W-1:0]   ram_dout_a,
    output logic                busy_o,
    output logic                done_irq_o
);

    bus_state_e        bus_state_q, bus_state_d;
    logic              ack_q, ack_d;
    logic [WB_W-1:0]   dat_q, dat_d;
    logic              rd_sel_q, rd_sel_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              done_q, done_d;
    port_req_t         port_q, port_d;

    port_req_t         bus_req;
    port_req_t         eng_req;
    logic              eng_busy;
    logic              eng_done;
    logic              start_clr;
    logic              start_scr;
    logic              done_clr;

    logic              req_seen;
    logic              is_reg;
    logic [ADDR_W-1:0] cell_adr;
    logic              in_range;
    logic [1:0]        reg_off;
    logic              unused_dat_bits;

    assign req_seen        = bus.wb_cyc_i && bus.wb_stb_i;
    assign is_reg          = bus.wb_adr_i[10];
    assign cell_adr        = bus.wb_adr_i[ADDR_W-1:0];
    assign in_range        = cell_adr < CELLS_A;
    assign reg_off         = bus.wb_adr_i[1:0];
    assign unused_dat_bits = ^bus.wb_dat_i[WB_W-1:DATA_W];

    char_ram_engine u_engine (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_clr_i (start_clr),
        .start_scr_i (start_scr),
        .fill_i      (fill_q),
        .req_o       (eng_req),
        .busy_o      (eng_busy),
        .done_irq_o  (eng_done)
    );

    // Wishbone decode, register access and CPU port-A request.
    always_comb begin
        bus_state_d = bus_state_q;
        ack_d       = 1'b0;
        dat_d       = '0;
        rd_sel_d    = 1'b0;
        fill_d      = fill_q;
        done_clr    = 1'b0;
        start_clr   = 1'b0;
        start_scr   = 1'b0;
        bus_req     = '0;

        case (bus_state_q)
            BUS_IDLE: begin
                if (req_seen) begin
                    if (is_reg) begin
                        // Registers are serviced even while the engine runs.
                        ack_d       = 1'b1;
                        bus_state_d = BUS_ACK;
                        case (reg_off)
                            REG_CTRL: begin
                                if (bus.wb_we_i) begin
                                    start_clr = bus.wb_dat_i[CTRL_CLR_BIT];
                                    start_scr = bus.wb_dat_i[CTRL_SCR_BIT];
                                end
                            end
                            REG_FILL: begin
                                if (bus.wb_we_i) fill_d = bus.wb_dat_i[DATA_W-1:0];
                                else             dat_d[DATA_W-1:0] = fill_q;
                            end
                            REG_STATUS: begin
                                if (bus.wb_we_i) begin
                                    done_clr = bus.wb_dat_i[STAT_DONE_BIT];
                                end else begin
                                    dat_d[STAT_BUSY_BIT] = eng_busy;
                                    dat_d[STAT_DONE_BIT] = done_q;
                                end
                            end
                            default: ;
                        endcase
                    end else if (!in_range) begin
                        // Outside the screen: no RAM op, reads return zero.
                        ack_d       = 1'b1;
                        bus_state_d = BUS_ACK;
                    end else if (!eng_busy) begin
                        bus_req.ce   = 1'b1;
                        bus_req.we   = bus.wb_we_i;
                        bus_req.addr = cell_adr;
                        bus_req.din  = bus.wb_dat_i[DATA_W-1:0];
                        if (bus.wb_we_i) begin
                            ack_d       = 1'b1;
                            bus_state_d = BUS_ACK;
                        end else begin
                            bus_state_d = BUS_RD_WAIT;
                        end
                    end
                    // In-range RAM access while busy: stay here, ack withheld.
                end
            end

            BUS_RD_WAIT: begin
                if (!bus.wb_cyc_i) begin
                    bus_state_d = BUS_IDLE;
                end else begin
                    ack_d       = 1'b1;
                    rd_sel_d    = 1'b1;
                    bus_state_d = BUS_ACK;
                end
            end

            BUS_ACK: bus_state_d = BUS_IDLE;

            default: bus_state_d = BUS_IDLE;
        endcase

        // Completion sets done even if software clears it in the same cycle.
        if (eng_done)      done_d = 1'b1;
        else if (done_clr) done_d = 1'b0;
        else               done_d = done_q;

        // The engine has port A whenever it requests it.
        port_d = eng_req.ce ? eng_req : bus_req;
    end

    // Bus FSM, registers and registered port-A outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state_q <= BUS_IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            rd_sel_q    <= 1'b0;
            fill_q      <= '0;
            done_q      <= 1'b0;
            port_q      <= '0;
        end else begin
            bus_state_q <= bus_state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            rd_sel_q    <= rd_sel_d;
            fill_q      <= fill_d;
            done_q      <= done_d;
            port_q      <= port_d;
        end
    end

    // Read data comes from the RAM's own output register, which is valid in
    // the ack cycle; re-registering it would cost a cycle of latency. The
    // same applies to the scroll copy path into ram_din_a.
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = rd_sel_q ? {{(WB_W-DATA_W){1'b0}}, ram_dout_a} : dat_q;

    assign ram_ce_a   = port_q.ce;
    assign ram_we_a   = port_q.we;
    assign ram_addr_a = port_q.addr;
    assign ram_din_a  = port_q.din_from_rd ? ram_dout_a : port_q.din;

    assign busy_o     = eng_busy;
    assign done_irq_o = eng_done;

endmodule
